// File: rtl/seg_pkg.sv
// Shared seven-segment constants: active-high hex glyph table in {g,f,e,d,c,b,a} order,
// the blank pattern and the segment bit positions.
package seg_pkg;

  localparam int unsigned SEG_A = 0;
  localparam int unsigned SEG_B = 1;
  localparam int unsigned SEG_C = 2;
  localparam int unsigned SEG_D = 3;
  localparam int unsigned SEG_E = 4;
  localparam int unsigned SEG_F = 5;
  localparam int unsigned SEG_G = 6;

  localparam logic [6:0] SEG_OFF = 7'h00;

  // Index 0 is leftmost so the table reads 0..F.
  localparam logic [0:15][6:0] HEX_SEG = {
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-high seven-segment pattern {g..a}.
module hex_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] val_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = HEX_SEG[val_i];
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed seven-segment driver with per-digit enable, blink and decimal point.
// Display contents are swapped only at frame boundaries so a scan never mixes old and new values.
module seven_seg_scanner
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned GUARD        = 2000,
  parameter int unsigned BLINK_FRAMES = 125,
  parameter int unsigned ACTIVE_LOW   = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digit_val,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [NUM_DIGITS-1:0]   blink_en,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int unsigned TickW  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IdxW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned FrameW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic        Pol    = (ACTIVE_LOW != 0);

  logic [TickW-1:0]  tick_q, tick_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [FrameW-1:0] frame_cnt_q, frame_cnt_d;
  logic              blink_ph_q, blink_ph_d;

  logic [4*NUM_DIGITS-1:0] pend_val_q, pend_val_d, disp_val_q, disp_val_d;
  logic [NUM_DIGITS-1:0]   pend_en_q, pend_en_d, disp_en_q, disp_en_d;
  logic [NUM_DIGITS-1:0]   pend_blink_q, pend_blink_d, disp_blink_q, disp_blink_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;

  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic                  frame_done_q, frame_done_d;

  logic tick_last, idx_last, frame_end, frame_last;

  logic [3:0]            sel_val;
  logic                  sel_en, sel_blink, sel_dp;
  logic [NUM_DIGITS-1:0] an_hot;
  logic [6:0]            sel_seg;
  logic                  in_guard, show;

  always_comb begin
    tick_last  = (tick_q == TickW'(REFRESH_DIV - 1));
    idx_last   = (idx_q == IdxW'(NUM_DIGITS - 1));
    frame_end  = tick_last && idx_last;
    frame_last = (frame_cnt_q == FrameW'(BLINK_FRAMES - 1));

    tick_d = tick_last ? '0 : tick_q + TickW'(1);
    idx_d  = idx_q;
    if (tick_last) begin
      idx_d = idx_last ? '0 : idx_q + IdxW'(1);
    end
    frame_cnt_d = frame_cnt_q;
    if (frame_end) begin
      frame_cnt_d = frame_last ? '0 : frame_cnt_q + FrameW'(1);
    end
    blink_ph_d = blink_ph_q ^ (frame_end && frame_last);
  end

  always_comb begin
    pend_val_d   = load ? digit_val : pend_val_q;
    pend_en_d    = load ? digit_en  : pend_en_q;
    pend_blink_d = load ? blink_en  : pend_blink_q;
    pend_dp_d    = load ? dp_in     : pend_dp_q;

    // A load landing exactly on frame end bypasses the pending set for zero-frame latency.
    disp_val_d   = disp_val_q;
    disp_en_d    = disp_en_q;
    disp_blink_d = disp_blink_q;
    disp_dp_d    = disp_dp_q;
    if (frame_end) begin
      disp_val_d   = pend_val_d;
      disp_en_d    = pend_en_d;
      disp_blink_d = pend_blink_d;
      disp_dp_d    = pend_dp_d;
    end
  end

  always_comb begin
    sel_val   = '0;
    sel_en    = 1'b0;
    sel_blink = 1'b0;
    sel_dp    = 1'b0;
    an_hot    = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IdxW'(i)) begin
        sel_val   = disp_val_q[4*i +: 4];
        sel_en    = disp_en_q[i];
        sel_blink = disp_blink_q[i];
        sel_dp    = disp_dp_q[i];
        an_hot[i] = 1'b1;
      end
    end
  end

  hex_to_seg u_hex_to_seg (
    .val_i (sel_val),
    .seg_o (sel_seg)
  );

  always_comb begin
    in_guard     = (32'(tick_q) < GUARD);
    show         = !in_guard && sel_en && !(sel_blink && blink_ph_q);
    an_d         = (in_guard ? '0 : an_hot) ^ {NUM_DIGITS{Pol}};
    seg_d        = (show ? sel_seg : SEG_OFF) ^ {7{Pol}};
    dp_d         = (show && sel_dp) ^ Pol;
    frame_done_d = frame_end;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_q       <= '0;
      idx_q        <= '0;
      frame_cnt_q  <= '0;
      blink_ph_q   <= 1'b0;
      pend_val_q   <= '0;
      pend_en_q    <= '0;
      pend_blink_q <= '0;
      pend_dp_q    <= '0;
      disp_val_q   <= '0;
      disp_en_q    <= '0;
      disp_blink_q <= '0;
      disp_dp_q    <= '0;
      an_q         <= {NUM_DIGITS{Pol}};
      seg_q        <= SEG_OFF ^ {7{Pol}};
      dp_q         <= Pol;
      frame_done_q <= 1'b0;
    end else begin
      tick_q       <= tick_d;
      idx_q        <= idx_d;
      frame_cnt_q  <= frame_cnt_d;
      blink_ph_q   <= blink_ph_d;
      pend_val_q   <= pend_val_d;
      pend_en_q    <= pend_en_d;
      pend_blink_q <= pend_blink_d;
      pend_dp_q    <= pend_dp_d;
      disp_val_q   <= disp_val_d;
      disp_en_q    <= disp_en_d;
      disp_blink_q <= disp_blink_d;
      disp_dp_q    <= disp_dp_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule
